// File: rtl/watchdog_supervisor.sv
// Supervises a watchdog's sticky alerts: raises irq, re-arms the watchdog, escalates to a timed system reset.
// Optional macro WATCHDOG_SUPERVISOR_TIMEOUT_EN: escalate when irq_ack does not arrive within ack_timeout cycles.
module watchdog_supervisor #(
   parameter int alert_threshold     = 3,
   parameter int rearm_cycles        = 4,
   parameter int system_reset_cycles = 16,
   parameter int ack_timeout         = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       alert_value_changed,
   input  logic       alert_value_unchanged,
   input  logic       irq_ack,
   input  logic       count_clear,
   output logic       watchdog_reset,
   output logic       irq,
   output logic [1:0] alert_cause,
   output logic [7:0] alert_count,
   output logic       system_reset
);

   typedef enum logic [2:0] {IDLE, REARM, ARMED, IRQ_WAIT, ESCALATE} state_t;

   // One shared cycle counter times REARM, ESCALATE and (when enabled) the ack wait.
   localparam int MAX_AB  = (rearm_cycles > system_reset_cycles) ? rearm_cycles : system_reset_cycles;
   localparam int MAX_CYC = (MAX_AB > ack_timeout) ? MAX_AB : ack_timeout;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       count_nxt, count_base, count_inc;
   logic [1:0]       cause_nxt;
   logic             alert;

   always_comb begin
      alert      = alert_value_changed | alert_value_unchanged;
      count_base = count_clear ? 8'd0 : alert_count;
      count_inc  = (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
      state_nxt  = state;
      cnt_nxt    = cnt;
      count_nxt  = (state == ESCALATE) ? alert_count : count_base;
      cause_nxt  = alert_cause;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = REARM;
               cnt_nxt   = '0;
            end
         end
         REARM: begin
            if (!enable)
               state_nxt = IDLE;
            else if (cnt == CNT_W'(rearm_cycles - 1))
               state_nxt = ARMED;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         ARMED: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (alert) begin
               cause_nxt = {alert_value_unchanged, alert_value_changed};
               count_nxt = count_inc;
               cnt_nxt   = '0;
               state_nxt = (int'(count_inc) >= alert_threshold) ? ESCALATE : IRQ_WAIT;
            end
         end
         IRQ_WAIT: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (irq_ack) begin
               state_nxt = REARM;
               cnt_nxt   = '0;
            end
`ifdef WATCHDOG_SUPERVISOR_TIMEOUT_EN
            else if (cnt == CNT_W'(ack_timeout - 1)) begin
               state_nxt = ESCALATE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
`endif
         end
         ESCALATE: begin
            // Runs to completion regardless of enable; the exit target honours it.
            if (cnt == CNT_W'(system_reset_cycles - 1)) begin
               count_nxt = 8'd0;
               cnt_nxt   = '0;
               state_nxt = enable ? REARM : IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         alert_count    <= 8'd0;
         alert_cause    <= 2'b00;
         watchdog_reset <= 1'b1;
         irq            <= 1'b0;
         system_reset   <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         alert_count    <= count_nxt;
         alert_cause    <= cause_nxt;
         watchdog_reset <= (state_nxt == IDLE) || (state_nxt == REARM);
         irq            <= (state_nxt == IRQ_WAIT);
         system_reset   <= (state_nxt == ESCALATE);
      end
   end

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Scoreboard bench for watchdog_supervisor: expected output vectors {wd, irq, sr, cause, count} queued per driven cycle.
module tb_watchdog_supervisor;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       alert_value_changed;
   logic       alert_value_unchanged;
   logic       irq_ack;
   logic       count_clear;
   logic       watchdog_reset;
   logic       irq;
   logic [1:0] alert_cause;
   logic [7:0] alert_count;
   logic       system_reset;

   int          errors = 0;
   int          checks = 0;
   logic [12:0] sb[$];
   logic [12:0] e;

   watchdog_supervisor dut (
      .clock                 (clock),
      .reset                 (reset),
      .enable                (enable),
      .alert_value_changed   (alert_value_changed),
      .alert_value_unchanged (alert_value_unchanged),
      .irq_ack               (irq_ack),
      .count_clear           (count_clear),
      .watchdog_reset        (watchdog_reset),
      .irq                   (irq),
      .alert_cause           (alert_cause),
      .alert_count           (alert_count),
      .system_reset          (system_reset)
   );

   always #5 clock = ~clock;

   function automatic logic [12:0] pk(input logic wd, input logic iq, input logic sr,
                                      input logic [1:0] cause, input logic [7:0] cnt);
      return {wd, iq, sr, cause, cnt};
   endfunction

   function automatic logic [12:0] obs();
      return {watchdog_reset, irq, system_reset, alert_cause, alert_count};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; alert_value_changed = 1'b0; alert_value_unchanged = 1'b0;
      irq_ack = 1'b0; count_clear = 1'b0;
      tick(); tick();
      sb.push_back(pk(1'b1, 1'b0, 1'b0, 2'b00, 8'd0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", obs(), e);
      end
   endtask

   // From IDLE (or reset release): 4 cycles of watchdog_reset, then ARMED.
   task automatic test_enable(input logic [1:0] cause, input logic [7:0] cnt);
      reset  = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(pk(i < 4, 1'b0, 1'b0, cause, cnt));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL enable_rearm cyc %0d: got %h want %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_alert_round(input logic ch, input logic un, input logic clr,
                                   input logic [7:0] cnt, input string name);
      alert_value_changed = ch; alert_value_unchanged = un; count_clear = clr;
      sb.push_back(pk(1'b0, 1'b1, 1'b0, {un, ch}, cnt));
      tick();
      count_clear = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL %s_irq: got %h want %h", name, obs(), e);
      end
      // Sticky alert held high must not be counted again.
      for (int i = 0; i < 3; i++) begin
         sb.push_back(pk(1'b0, 1'b1, 1'b0, {un, ch}, cnt));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL %s_sticky cyc %0d: got %h want %h", name, i, obs(), e);
         end
      end
      irq_ack = 1'b1; alert_value_changed = 1'b0; alert_value_unchanged = 1'b0;
      sb.push_back(pk(1'b1, 1'b0, 1'b0, {un, ch}, cnt));
      tick();
      irq_ack = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL %s_ack: got %h want %h", name, obs(), e);
      end
      for (int i = 1; i <= 4; i++) begin
         sb.push_back(pk(i < 4, 1'b0, 1'b0, {un, ch}, cnt));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL %s_rearm cyc %0d: got %h want %h", name, i, obs(), e);
         end
      end
   endtask

   task automatic test_escalation();
      test_alert_round(1'b0, 1'b1, 1'b0, 8'd2, "round2");
      alert_value_changed = 1'b1; alert_value_unchanged = 1'b1;
      sb.push_back(pk(1'b0, 1'b0, 1'b1, 2'b11, 8'd3));
      tick();
      alert_value_changed = 1'b0; alert_value_unchanged = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL esc_enter: got %h want %h", obs(), e);
      end
      for (int i = 1; i < 16; i++) begin
         irq_ack     = (i == 5);
         count_clear = (i == 7);
         sb.push_back(pk(1'b0, 1'b0, 1'b1, 2'b11, 8'd3));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL esc_hold cyc %0d: got %h want %h", i, obs(), e);
         end
      end
      irq_ack = 1'b0; count_clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(pk(i < 4, 1'b0, 1'b0, 2'b11, 8'd0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL esc_exit cyc %0d: got %h want %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_count_clear();
      test_alert_round(1'b1, 1'b0, 1'b0, 8'd1, "cc_a");
      test_alert_round(1'b1, 1'b0, 1'b0, 8'd2, "cc_b");
      test_alert_round(1'b1, 1'b0, 1'b1, 8'd1, "cc_with_alert");
      count_clear = 1'b1;
      sb.push_back(pk(1'b0, 1'b0, 1'b0, 2'b01, 8'd0));
      tick();
      count_clear = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL cc_armed: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_enable_drop();
      alert_value_unchanged = 1'b1;
      sb.push_back(pk(1'b0, 1'b1, 1'b0, 2'b10, 8'd1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL drop_irq: got %h want %h", obs(), e);
      end
      enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(pk(1'b1, 1'b0, 1'b0, 2'b10, 8'd1));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL drop_idle cyc %0d: got %h want %h", i, obs(), e);
         end
      end
      alert_value_unchanged = 1'b0;
      test_enable(2'b10, 8'd1);
   endtask

   task automatic test_reset_escalate();
      test_alert_round(1'b1, 1'b0, 1'b0, 8'd2, "pre_rst");
      alert_value_changed = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(pk(1'b0, 1'b0, 1'b1, 2'b01, 8'd3));
         tick();
         alert_value_changed = 1'b0;
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL rst_esc_pre cyc %0d: got %h want %h", i, obs(), e);
         end
      end
      #2 reset = 1'b0;
      sb.push_back(pk(1'b1, 1'b0, 1'b0, 2'b00, 8'd0));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL rst_esc_async: got %h want %h", obs(), e);
      end
      tick();
      test_enable(2'b00, 8'd0);
   endtask

`ifdef WATCHDOG_SUPERVISOR_TIMEOUT_EN
   task automatic test_timeout();
      for (int r = 0; r < 2; r++) begin
         alert_value_changed = 1'b1;
         for (int i = 0; i < 64; i++) begin
            sb.push_back(pk(1'b0, 1'b1, 1'b0, 2'b01, 8'd1));
            tick();
            alert_value_changed = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL to_wait r%0d cyc %0d: got %h want %h", r, i, obs(), e);
            end
         end
         if (r == 0) begin
            for (int i = 0; i < 21; i++) begin
               sb.push_back(i < 16 ? pk(1'b0, 1'b0, 1'b1, 2'b01, 8'd1)
                                   : pk(i < 20, 1'b0, 1'b0, 2'b01, 8'd0));
               tick();
               e = sb.pop_front();
               checks++;
               if (obs() !== e) begin
                  errors++;
                  $display("FAIL to_escalate cyc %0d: got %h want %h", i, obs(), e);
               end
            end
         end else begin
            irq_ack = 1'b1;
            sb.push_back(pk(1'b1, 1'b0, 1'b0, 2'b01, 8'd1));
            tick();
            irq_ack = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL to_ack_wins: got %h want %h", obs(), e);
            end
         end
      end
   endtask
`else
   task automatic test_no_timeout();
      alert_value_changed = 1'b1;
      for (int i = 0; i < 1001; i++) begin
         sb.push_back(pk(1'b0, 1'b1, 1'b0, 2'b01, 8'd1));
         tick();
         alert_value_changed = 1'b0;
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL no_timeout cyc %0d: got %h want %h", i, obs(), e);
         end
      end
      irq_ack = 1'b1;
      sb.push_back(pk(1'b1, 1'b0, 1'b0, 2'b01, 8'd1));
      tick();
      irq_ack = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL no_timeout_ack: got %h want %h", obs(), e);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got no finish want finish by 200000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_enable(2'b00, 8'd0);
      test_alert_round(1'b1, 1'b0, 1'b0, 8'd1, "single");
      test_escalation();
      test_count_clear();
      test_enable_drop();
      test_reset_escalate();
`ifdef WATCHDOG_SUPERVISOR_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
